// File: rtl/pwm_multi_channel.sv
// rtl/pwm_multi_channel.sv - multi-channel PWM generator with shadowed duty and shared period counter
//
// All channels share one prescaled period counter. The counter runs edge-aligned
// (saw-tooth) or center-aligned (triangle). Duty values are captured into a shadow
// register and only become active at a period boundary, so updates never glitch
// an output mid-period.
//
// Ports:
//   clk, rst       system clock, asynchronous active-high reset
//   enable         run/stop; low holds counter at 0 and outputs at their inactive level
//   top            period top value, taken at each period boundary
//   prescale       counter advances every prescale+1 clocks (used live)
//   center_mode    0 = edge-aligned, 1 = center-aligned; taken at each period boundary
//   polarity       per-channel output inversion (1 = active-low)
//   duty_in        flat duty bus, channel i at [i*RESOLUTION +: RESOLUTION]
//   duty_load      one-clock strobe capturing duty_in into the shadow register
//   load_pending   shadow holds values not yet active
//   period_start   one-clock pulse on the clock after each period boundary
//   pwm_out        registered PWM outputs

module pwm_multi_channel #(
    parameter int RESOLUTION = 8,
    parameter int CHANNELS   = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic [RESOLUTION-1:0]          top,
    input  logic [PRESCALE_W-1:0]          prescale,
    input  logic                           center_mode,
    input  logic [CHANNELS-1:0]            polarity,
    input  logic [CHANNELS*RESOLUTION-1:0] duty_in,
    input  logic                           duty_load,
    output logic                           load_pending,
    output logic                           period_start,
    output logic [CHANNELS-1:0]            pwm_out
);

    localparam logic [RESOLUTION-1:0] CNT_ONE   = RESOLUTION'(1);
    localparam logic [PRESCALE_W-1:0] PRESC_ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0]          r_presc_cnt;
    logic [RESOLUTION-1:0]          r_counter;
    logic                           r_dir_down;
    logic [RESOLUTION-1:0]          r_top_act;
    logic                           r_mode_act;
    logic [CHANNELS*RESOLUTION-1:0] r_shadow;
    logic [CHANNELS*RESOLUTION-1:0] r_duty_act;
    logic                           r_load_pending;
    logic                           r_period_start;
    logic [CHANNELS-1:0]            r_pwm;

    logic                           w_tick;
    logic [RESOLUTION-1:0]          w_cnt_next;
    logic                           w_dir_next;
    logic                           w_boundary;
    logic [CHANNELS-1:0]            w_raw;

    // Equality compare: if prescale shrinks below the running count, the count
    // wraps through 2^PRESCALE_W rather than ticking early.
    assign w_tick = (r_presc_cnt == prescale);

    // Next counter value and direction for a tick; w_boundary marks the tick
    // that returns the counter to 0 and closes a period.
    always_comb begin
        w_cnt_next = r_counter;
        w_dir_next = r_dir_down;
        w_boundary = 1'b0;
        if (r_top_act == '0) begin
            w_cnt_next = '0;
            w_dir_next = 1'b0;
            w_boundary = 1'b1;
        end else if (!r_mode_act) begin
            if (r_counter >= r_top_act) begin
                w_cnt_next = '0;
                w_dir_next = 1'b0;
                w_boundary = 1'b1;
            end else begin
                w_cnt_next = r_counter + CNT_ONE;
            end
        end else if (!r_dir_down && (r_counter < r_top_act)) begin
            w_cnt_next = r_counter + CNT_ONE;
        end else if (r_counter <= CNT_ONE) begin
            // Down-count reaching 0 (or top_act==1 turning at the peak) ends the period.
            w_cnt_next = '0;
            w_dir_next = 1'b0;
            w_boundary = 1'b1;
        end else begin
            w_cnt_next = r_counter - CNT_ONE;
            w_dir_next = 1'b1;
        end
    end

    always_comb begin
        w_raw = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_raw[i] = (r_counter < r_duty_act[i*RESOLUTION +: RESOLUTION]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc_cnt    <= '0;
            r_counter      <= '0;
            r_dir_down     <= 1'b0;
            r_top_act      <= '0;
            r_mode_act     <= 1'b0;
            r_shadow       <= '0;
            r_duty_act     <= '0;
            r_load_pending <= 1'b0;
            r_period_start <= 1'b0;
            r_pwm          <= '0;
        end else begin
            if (!enable) begin
                // Idle: configuration tracks the inputs so the first enabled
                // period starts with current values.
                r_presc_cnt    <= '0;
                r_counter      <= '0;
                r_dir_down     <= 1'b0;
                r_period_start <= 1'b0;
                r_top_act      <= top;
                r_mode_act     <= center_mode;
                r_duty_act     <= r_shadow;
                r_load_pending <= 1'b0;
                r_pwm          <= polarity;
            end else begin
                r_period_start <= 1'b0;
                r_pwm          <= w_raw ^ polarity;
                if (w_tick) begin
                    r_presc_cnt <= '0;
                    r_counter   <= w_cnt_next;
                    r_dir_down  <= w_dir_next;
                    if (w_boundary) begin
                        r_period_start <= 1'b1;
                        r_top_act      <= top;
                        r_mode_act     <= center_mode;
                        if (r_load_pending) begin
                            r_duty_act     <= r_shadow;
                            r_load_pending <= 1'b0;
                        end
                    end
                end else begin
                    r_presc_cnt <= r_presc_cnt + PRESC_ONE;
                end
            end
            // A load coinciding with a boundary lets the boundary take the old
            // shadow while the new value stays pending for the next one.
            if (duty_load) begin
                r_shadow       <= duty_in;
                r_load_pending <= 1'b1;
            end
        end
    end

    assign load_pending = r_load_pending;
    assign period_start = r_period_start;
    assign pwm_out      = r_pwm;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb/tb_pwm_multi_channel.sv - scoreboard testbench for pwm_multi_channel

module tb_pwm_multi_channel;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [7:0]  top;
    logic [7:0]  prescale;
    logic        center_mode;
    logic [3:0]  polarity;
    logic [31:0] duty_in;
    logic        duty_load;
    logic        load_pending;
    logic        period_start;
    logic [3:0]  pwm_out;

    pwm_multi_channel #(.RESOLUTION(8), .CHANNELS(4), .PRESCALE_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .top          (top),
        .prescale     (prescale),
        .center_mode  (center_mode),
        .polarity     (polarity),
        .duty_in      (duty_in),
        .duty_load    (duty_load),
        .load_pending (load_pending),
        .period_start (period_start),
        .pwm_out      (pwm_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] pwm;
        logic       ps;
        logic       lp;
        logic       chk_ps;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    function automatic void push(int c, logic [3:0] p, logic ps, logic lp, logic cps, string n);
        exp_t e;
        e.cyc = c; e.pwm = p; e.ps = ps; e.lp = lp; e.chk_ps = cps; e.name = n;
        sb.push_back(e);
    endfunction

    function automatic logic [3:0] model(int cnt, int d0, int d1, int d2, int d3, logic [3:0] pol);
        logic [3:0] r;
        r[0] = (cnt < d0);
        r[1] = (cnt < d1);
        r[2] = (cnt < d2);
        r[3] = (cnt < d3);
        return r ^ pol;
    endfunction

    // Monitor: outputs are valid every clock; compare against entries due now.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            checks++;
            if (mon_e.cyc < cyc) begin
                errors++;
                $display("FAIL %s: entry for cycle %0d not compared (now %0d)", mon_e.name, mon_e.cyc, cyc);
            end else if (pwm_out !== mon_e.pwm || load_pending !== mon_e.lp ||
                         (mon_e.chk_ps && period_start !== mon_e.ps)) begin
                errors++;
                $display("FAIL %s cyc=%0d: pwm_out=%b exp %b, period_start=%b exp %b, load_pending=%b exp %b",
                         mon_e.name, cyc, pwm_out, mon_e.pwm, period_start, mon_e.ps, load_pending, mon_e.lp);
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_duty(int d0, int d1, int d2, int d3);
        duty_in   = {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
        duty_load = 1'b1;
        step(1);
        duty_load = 1'b0;
    endtask

    function automatic int t3_duty(int k);
        if (k <= 9)  return 2;
        if (k <= 19) return 7;
        if (k <= 29) return 5;
        return 4;
    endfunction

    int base;
    int cnt;
    int center_seq [8] = '{0, 1, 2, 3, 4, 3, 2, 1};

    initial begin
        rst = 1'b1; enable = 1'b0; top = '0; prescale = '0; center_mode = 1'b0;
        polarity = '0; duty_in = '0; duty_load = 1'b0;

        step(2);
        push(cyc, 4'b0000, 1'b0, 1'b0, 1'b1, "reset");
        step(1);
        rst = 1'b0;

        // Edge mode, top=9, duties 0,3,10,5
        top = 8'd9;
        load_duty(0, 3, 10, 5);
        push(cyc,     4'b0000, 1'b0, 1'b1, 1'b1, "idle_load_pending");
        push(cyc + 1, 4'b0000, 1'b0, 1'b0, 1'b1, "idle_load_applied");
        step(2);
        base = cyc + 1;
        enable = 1'b1;
        for (int k = 0; k < 30; k++)
            push(base + k, model(k % 10, 0, 3, 10, 5, 4'b0000), (k % 10) == 9, 1'b0, 1'b1, "edge_basic");
        step(30);

        // Polarity: idle level then inverted channels 1 and 3
        enable = 1'b0;
        step(1);
        polarity = 4'b1010;
        step(1);
        push(cyc, 4'b1010, 1'b0, 1'b0, 1'b1, "pol_idle");
        base = cyc + 1;
        enable = 1'b1;
        for (int k = 0; k < 10; k++)
            push(base + k, model(k, 0, 3, 10, 5, 4'b1010), k == 9, 1'b0, 1'b1, "pol_run");
        step(10);
        enable = 1'b0;
        polarity = 4'b0000;

        // Shadow loads: mid-period, then one coinciding with a boundary
        load_duty(2, 2, 2, 2);
        step(1);
        base = cyc + 1;
        enable = 1'b1;
        for (int k = 0; k < 40; k++) begin
            cnt = t3_duty(k);
            push(base + k, model(k % 10, cnt, cnt, cnt, cnt, 4'b0000), (k % 10) == 9,
                 ((k >= 3 && k <= 8) || (k >= 12 && k <= 28)), 1'b1, "shadow_load");
        end
        step(3);
        load_duty(7, 7, 7, 7);
        step(8);
        load_duty(5, 5, 5, 5);
        step(6);
        load_duty(4, 4, 4, 4);
        step(20);

        // Prescale=2, top=3, duty=2; prescale dropped to 0 mid-period
        enable = 1'b0;
        top = 8'd3;
        prescale = 8'd2;
        load_duty(2, 2, 2, 2);
        step(1);
        base = cyc + 1;
        enable = 1'b1;
        for (int k = 0; k <= 290; k++) begin
            if (k <= 30)
                push(base + k, model((k / 3) % 4, 2, 2, 2, 2, 4'b0000), (k % 12) == 11, 1'b0, 1'b1, "presc_run");
            else if (k <= 287)
                push(base + k, 4'b0000, k == 287, 1'b0, 1'b1, "presc_wrap");
            else
                push(base + k, (k == 290) ? 4'b0000 : 4'b1111, 1'b0, 1'b0, 1'b1, "presc_after");
        end
        step(31);
        prescale = 8'd0;
        step(260);

        // Center-aligned, top=4, duty=2
        enable = 1'b0;
        top = 8'd4;
        center_mode = 1'b1;
        step(2);
        base = cyc + 1;
        enable = 1'b1;
        for (int k = 0; k < 24; k++)
            push(base + k, model(center_seq[k % 8], 2, 2, 2, 2, 4'b0000), (k % 8) == 7, 1'b0, 1'b1, "center");
        step(24);

        // Reset mid-period with a pending load
        load_duty(3, 3, 3, 3);
        push(cyc, 4'b1111, 1'b0, 1'b1, 1'b1, "pending_before_rst");
        step(2);
        rst = 1'b1;
        push(cyc, 4'b0000, 1'b0, 1'b0, 1'b1, "rst_async");
        step(1);
        push(cyc, 4'b0000, 1'b0, 1'b0, 1'b1, "rst_held");
        rst = 1'b0;
        base = cyc + 1;
        for (int k = 0; k < 20; k++)
            push(base + k, 4'b0000, 1'b0, 1'b0, 1'b0, "after_rst");
        step(20);

        step(2);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
